// File: rtl/mem_host_initiator.sv
// Burst-capable host-side initiator for the 4-bank SRAM memory controller.
// Turns one START command into a sequence of per-byte SRAM accesses:
// writes pull bytes from a valid/ready stream, reads return a one-cycle
// RDATA_VLD pulse per byte. All pins except WDATA_RDY are registered.
module mem_host_initiator #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 9,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              OP,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WDATA_VLD,
  output logic              WDATA_RDY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RDATA_VLD,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CE,
  output logic              CSB,
  output logic              WEB,
  output logic              OEB,
  output logic [DATA_W-1:0] IDATA,
  input  logic [DATA_W-1:0] ODATA
);

  // RD_WAIT occupies RD_LAT cycles; the counter is preloaded with RD_LAT-1
  // and ODATA is captured when it reaches zero.
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WD,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RD_WAIT,
    S_FINISH
  } state_t;

  state_t              state_q;
  logic                op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic [2:0]          lat_q;
  logic [ADDR_W-1:0]   pin_addr_q;
  logic                ce_q;
  logic                csb_q;
  logic                web_q;
  logic                oeb_q;
  logic [DATA_W-1:0]   idata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvld_q;
  logic                busy_q;
  logic                done_q;
  logic                last_byte;

  // The byte being retired is the final one of the burst.
  assign last_byte = (rem_q == {{(LEN_W-1){1'b0}}, 1'b1});

  // Burst sequencer; every pin is set on the transition into the state
  // in which it must be visible, so all outputs come straight from flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      lat_q      <= '0;
      pin_addr_q <= '0;
      ce_q       <= 1'b0;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      oeb_q      <= 1'b1;
      idata_q    <= '0;
      rdata_q    <= '0;
      rvld_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ce_q   <= 1'b0;
      rvld_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if (LEN == '0) begin
              // Empty burst: pins are already idle, just report completion.
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              op_q   <= OP;
              addr_q <= BASE_ADDR;
              rem_q  <= LEN;
              busy_q <= 1'b1;
              if (OP) begin
                state_q    <= S_SETUP;
                pin_addr_q <= BASE_ADDR;
                csb_q      <= 1'b0;
                web_q      <= 1'b1;
                oeb_q      <= 1'b0;
              end else begin
                state_q <= S_WAIT_WD;
              end
            end
          end
        end
        S_WAIT_WD: begin
          if (WDATA_VLD) begin
            idata_q    <= WDATA;
            pin_addr_q <= addr_q;
            csb_q      <= 1'b0;
            web_q      <= 1'b0;
            oeb_q      <= 1'b1;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          ce_q    <= 1'b1;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          if (op_q) begin
            lat_q   <= LAT_INIT;
            state_q <= S_RD_WAIT;
          end else begin
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          rem_q  <= rem_q - 1'b1;
          addr_q <= addr_q + 1'b1;
          if (last_byte) begin
            state_q <= S_FINISH;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            oeb_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT_WD;
          end
        end
        S_RD_WAIT: begin
          if (lat_q == '0) begin
            rdata_q <= ODATA;
            rvld_q  <= 1'b1;
            rem_q   <= rem_q - 1'b1;
            addr_q  <= addr_q + 1'b1;
            if (last_byte) begin
              state_q <= S_FINISH;
              csb_q   <= 1'b1;
              web_q   <= 1'b1;
              oeb_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // Address wraps modulo 2^ADDR_W naturally.
              state_q    <= S_SETUP;
              pin_addr_q <= addr_q + 1'b1;
            end
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign WDATA_RDY = (state_q == S_WAIT_WD);
  assign RDATA     = rdata_q;
  assign RDATA_VLD = rvld_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ADDR      = pin_addr_q;
  assign CE        = ce_q;
  assign CSB       = csb_q;
  assign WEB       = web_q;
  assign OEB       = oeb_q;
  assign IDATA     = idata_q;

endmodule
